// File: rtl/interrupt_arbiter_if.sv
// Connection bundle between the fetch-stage PC logic, interrupt sources and the
// interrupt arbiter. The master side drives requests and PC, the slave side answers.
interface interrupt_arbiter_if #(
  parameter int NUM_SRC = 8
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] irq_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [31:0]        pc_next;
  logic               return_from_isr;
  logic               pipeline_stall;
  logic [31:0]        pc_next_final;
  logic [31:0]        epc;
  logic               isr_active;
  logic [NUM_SRC-1:0] irq_ack;
  logic [ID_W-1:0]    active_id;

  modport master (
    output irq_in, mask_we, mask_wdata, pc_next, return_from_isr, pipeline_stall,
    input  pc_next_final, epc, isr_active, irq_ack, active_id
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, pc_next, return_from_isr, pipeline_stall,
    output pc_next_final, epc, isr_active, irq_ack, active_id
  );
endinterface

// File: rtl/interrupt_arbiter.sv
// Edge-triggered, maskable, fixed-priority interrupt controller that redirects the
// fetch PC to a per-source vector and restores the interrupted PC on ISR return.
module interrupt_arbiter #(
  parameter int          NUM_SRC       = 8,
  parameter logic [31:0] VECTOR_BASE   = 32'd500,
  parameter logic [31:0] VECTOR_STRIDE = 32'd16
) (
  input logic               clk,
  input logic               reset,
  interrupt_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_IN_ISR   = 2'd2,
    ST_RETURN   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               isr_active_r;
  logic [NUM_SRC-1:0] irq_in_d_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] mask_r;
  logic [31:0]        epc_r;
  logic [ID_W-1:0]    active_id_r;

  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] active_onehot_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [ID_W-1:0]    winner_s;
  logic               winner_vld_s;
  logic               dispatch_start_s;
  logic [31:0]        vector_s;
  logic [31:0]        pc_next_final_s;
  logic [NUM_SRC-1:0] irq_ack_s;

  assign rise_s           = bus.irq_in & ~irq_in_d_r;
  assign eligible_s       = pending_r & mask_r;
  assign winner_vld_s     = |eligible_s;
  assign active_onehot_s  = {{(NUM_SRC-1){1'b0}}, 1'b1} << active_id_r;
  assign clr_s            = (state_r == ST_DISPATCH) ? active_onehot_s : {NUM_SRC{1'b0}};
  assign dispatch_start_s = (state_r == ST_IDLE) && (state_next_s == ST_DISPATCH);
  assign vector_s         = VECTOR_BASE + (32'(active_id_r) * VECTOR_STRIDE);

  // Lowest eligible index wins: scan downward so the last hit is the smallest.
  always_comb begin
    winner_s = {ID_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      winner_s = eligible_s[i] ? ID_W'(i) : winner_s;
    end
  end

  // State register; isr_active is the registered decode of the next state.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      isr_active_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      isr_active_r <= (state_next_s != ST_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (winner_vld_s && !bus.pipeline_stall) begin
          state_next_s = ST_DISPATCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DISPATCH: state_next_s = ST_IN_ISR;
      ST_IN_ISR: begin
        if (bus.return_from_isr) begin
          state_next_s = ST_RETURN;
        end else begin
          state_next_s = ST_IN_ISR;
        end
      end
      ST_RETURN: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Request capture, mask and saved context; a new rise beats the dispatch clear.
  always_ff @(negedge clk) begin
    if (reset) begin
      irq_in_d_r  <= {NUM_SRC{1'b0}};
      pending_r   <= {NUM_SRC{1'b0}};
      mask_r      <= {NUM_SRC{1'b1}};
      epc_r       <= 32'd0;
      active_id_r <= {ID_W{1'b0}};
    end else begin
      irq_in_d_r <= bus.irq_in;
      pending_r  <= (pending_r & ~clr_s) | rise_s;
      if (bus.mask_we) begin
        mask_r <= bus.mask_wdata;
      end
      if (dispatch_start_s) begin
        active_id_r <= winner_s;
        epc_r       <= bus.pc_next;
      end
    end
  end

  // PC redirect and acknowledge decode; held neutral while reset is asserted.
  always_comb begin
    pc_next_final_s = bus.pc_next;
    irq_ack_s       = {NUM_SRC{1'b0}};
    if (reset) begin
      pc_next_final_s = bus.pc_next;
      irq_ack_s       = {NUM_SRC{1'b0}};
    end else begin
      case (state_r)
        ST_DISPATCH: begin
          pc_next_final_s = vector_s;
          irq_ack_s       = active_onehot_s;
        end
        ST_RETURN: begin
          pc_next_final_s = epc_r;
          irq_ack_s       = {NUM_SRC{1'b0}};
        end
        default: begin
          pc_next_final_s = bus.pc_next;
          irq_ack_s       = {NUM_SRC{1'b0}};
        end
      endcase
    end
  end

  assign bus.pc_next_final = pc_next_final_s;
  assign bus.irq_ack       = irq_ack_s;
  assign bus.epc           = epc_r;
  assign bus.isr_active    = isr_active_r;
  assign bus.active_id     = active_id_r;
endmodule
